// File: rtl/cpu_pkg.sv
// Shared decode constants and ALU operation encoding for the rv32i_core slice.
// CPU_MUL_EN adds the RV32M multiply operations to the ALU op set.
package cpu_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU
  } alu_op_t;

  // alt selects SUB/SRA; callers pass 0 for ADDI so imm bit 30 is not misread.
  function automatic alu_op_t alu_op_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Integer ALU with branch compare flags; CPU_MUL_EN adds single-cycle MUL/MULH/MULHSU/MULHU.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_op_t     op_i,
  output logic [31:0] result_o,
  output logic        eq_o,
  output logic        lt_o,
  output logic        ltu_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];
  assign eq_o  = (a_i == b_i);
  assign lt_o  = ($signed(a_i) < $signed(b_i));
  assign ltu_o = (a_i < b_i);

`ifdef CPU_MUL_EN
  // One 66-bit product serves all three high variants by choosing the operand extension.
  logic        a_ext, b_ext;
  logic [65:0] mul_a, mul_b, prod;
  assign a_ext = ((op_i == ALU_MULH) || (op_i == ALU_MULHSU)) && a_i[31];
  assign b_ext = (op_i == ALU_MULH) && b_i[31];
  assign mul_a = {{34{a_ext}}, a_i};
  assign mul_b = {{34{b_ext}}, b_i};
  assign prod  = mul_a * mul_b;
`endif

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SLT:  result_o = {31'd0, lt_o};
      ALU_SLTU: result_o = {31'd0, ltu_o};
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = $signed(a_i) >>> shamt;
      ALU_OR:   result_o = a_i | b_i;
      ALU_AND:  result_o = a_i & b_i;
`ifdef CPU_MUL_EN
      ALU_MUL:    result_o = prod[31:0];
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU:  result_o = prod[63:32];
`endif
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_core.sv
// Single-cycle RV32I core: fetch, decode, execute and retire in one clock.
// Define CPU_MUL_EN to decode the RV32M multiply instructions; otherwise they are NOPs.
module rv32i_core
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr_data,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wenable,
  input  logic [31:0] data_rdata
);

  logic [31:0] pc_q, pc_d, pc_plus4;
  logic [31:0] regs_q [1:31];

  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, agen;
  logic [1:0]  addr_lo;
  logic [31:0] ld_shift;
  logic [15:0] ld_half;

  alu_op_t     alu_op;
  logic [31:0] alu_b, alu_res;
  logic        alu_eq, alu_lt, alu_ltu;
  logic        rd_we, taken;
  logic [31:0] rd_wdata;
  logic [3:0]  wen;

  assign opcode = instr_data[6:0];
  assign rd     = instr_data[11:7];
  assign funct3 = instr_data[14:12];
  assign rs1    = instr_data[19:15];
  assign rs2    = instr_data[24:20];
  assign funct7 = instr_data[31:25];

  assign imm_i = {{20{instr_data[31]}}, instr_data[31:20]};
  assign imm_s = {{20{instr_data[31]}}, instr_data[31:25], instr_data[11:7]};
  assign imm_b = {{19{instr_data[31]}}, instr_data[31], instr_data[7], instr_data[30:25],
                  instr_data[11:8], 1'b0};
  assign imm_u = {instr_data[31:12], 12'd0};
  assign imm_j = {{11{instr_data[31]}}, instr_data[31], instr_data[19:12], instr_data[20],
                  instr_data[30:21], 1'b0};

  assign rs1_val  = (rs1 == 5'd0) ? '0 : regs_q[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? '0 : regs_q[rs2];
  assign agen     = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign addr_lo  = agen[1:0];
  assign ld_shift = data_rdata >> {addr_lo, 3'b000};
  assign ld_half  = addr_lo[1] ? data_rdata[31:16] : data_rdata[15:0];
  assign pc_plus4 = pc_q + 32'd4;

  cpu_alu u_alu (
    .a_i      (rs1_val),
    .b_i      (alu_b),
    .op_i     (alu_op),
    .result_o (alu_res),
    .eq_o     (alu_eq),
    .lt_o     (alu_lt),
    .ltu_o    (alu_ltu)
  );

  always_comb begin
    case (funct3)
      F3_BEQ:  taken = alu_eq;
      F3_BNE:  taken = !alu_eq;
      F3_BLT:  taken = alu_lt;
      F3_BGE:  taken = !alu_lt;
      F3_BLTU: taken = alu_ltu;
      F3_BGEU: taken = !alu_ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    alu_b      = rs2_val;
    alu_op     = ALU_ADD;
    rd_we      = 1'b0;
    rd_wdata   = alu_res;
    pc_d       = pc_plus4;
    wen        = '0;
    data_wdata = rs2_val;
    case (opcode)
      OP_LUI:   begin rd_we = 1'b1; rd_wdata = imm_u; end
      OP_AUIPC: begin rd_we = 1'b1; rd_wdata = pc_q + imm_u; end
      OP_JAL:   begin rd_we = 1'b1; rd_wdata = pc_plus4; pc_d = pc_q + imm_j; end
      OP_JALR: if (funct3 == 3'b000) begin
        rd_we    = 1'b1;
        rd_wdata = pc_plus4;
        pc_d     = {agen[31:1], 1'b0};
      end
      OP_BRANCH: if (taken) pc_d = pc_q + imm_b;
      OP_LOAD: begin
        rd_we = 1'b1;
        case (funct3)
          F3_B:    rd_wdata = {{24{ld_shift[7]}}, ld_shift[7:0]};
          F3_BU:   rd_wdata = {24'd0, ld_shift[7:0]};
          F3_H:    rd_wdata = {{16{ld_half[15]}}, ld_half};
          F3_HU:   rd_wdata = {16'd0, ld_half};
          F3_W:    rd_wdata = data_rdata;
          default: rd_we = 1'b0;
        endcase
      end
      OP_STORE: case (funct3)
        F3_W: wen = 4'b1111;
        F3_H: begin wen = 4'b0011 << {addr_lo[1], 1'b0}; data_wdata = {2{rs2_val[15:0]}}; end
        F3_B: begin wen = 4'b0001 << addr_lo; data_wdata = {4{rs2_val[7:0]}}; end
        default: wen = '0;
      endcase
      OP_IMM: begin
        alu_b  = imm_i;
        alu_op = alu_op_from_f3(funct3, (funct3 == F3_SR) && funct7[5]);
        rd_we  = ((funct3 != F3_SLL) && (funct3 != F3_SR)) || (funct7 == F7_BASE)
                 || ((funct3 == F3_SR) && (funct7 == F7_ALT));
      end
      OP_OP: begin
        alu_op = alu_op_from_f3(funct3, funct7[5]);
        rd_we  = (funct7 == F7_BASE)
                 || ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR)));
`ifdef CPU_MUL_EN
        if ((funct7 == F7_MULDIV) && !funct3[2]) begin
          rd_we = 1'b1;
          case (funct3[1:0])
            2'b00:   alu_op = ALU_MUL;
            2'b01:   alu_op = ALU_MULH;
            2'b10:   alu_op = ALU_MULHSU;
            default: alu_op = ALU_MULHU;
          endcase
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      for (int unsigned i = 1; i < 32; i++) regs_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      if (rd_we && (rd != 5'd0)) regs_q[rd] <= rd_wdata;
    end
  end

  assign instr_addr   = pc_q;
  assign data_addr    = agen;
  assign data_wenable = rst_n ? wen : 4'b0000;

endmodule

// File: tb/tb_rv32i_core.sv
// Directed program run against rv32i_core; per-cycle expectations queued while assembling.
module tb_rv32i_core;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_addr, instr_data, data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wenable;

  rv32i_core #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_addr   (instr_addr),
    .instr_data   (instr_data),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_wenable (data_wenable),
    .data_rdata   (data_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] rom [0:511];
  assign instr_data = rom[instr_addr[10:2]];
  assign data_rdata = (data_addr[31:2] == 30'h2000_0000) ? 32'h8081_F0FF : 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic        chk_addr;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] apc;
  int          checks = 0;
  int          errors = 0;

  int unsigned alu_regs [18] = '{2, 3, 4, 0, 20, 21, 22, 23, 24, 25, 26, 27, 28, 29, 30, 31, 19, 18};
  logic [31:0] alu_vals [18] = '{32'hFFFF_FFFF, 32'h0000_000F, 32'h1, 32'h0, 32'h10, 32'hFFFF_FFF0,
                                 32'h1, 32'h0007_8000, 32'h0001_FFFF, 32'h10, 32'h0007_8001, 32'hF,
                                 32'hF0, 32'h123, 32'hFFFF_FFF0, 32'h1, 32'h1, 32'h8000_0000};
  int unsigned ld_regs [6] = '{9, 10, 11, 12, 13, 14};
  logic [31:0] ld_vals [6] = '{32'hFFFF_FFFF, 32'h0000_00F0, 32'hFFFF_8081, 32'h8081_F0FF,
                               32'h0000_F0FF, 32'hFFFF_FF80};

  function automatic logic [31:0] r_t(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] i_t(input int imm, input int rs1, input int f3, input int rd, input int opc);
    return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'(opc)};
  endfunction
  function automatic logic [31:0] s_t(input int imm, input int rs2, input int rs1, input int f3);
    logic [11:0] v;
    v = 12'(imm);
    return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] b_t(input int imm, input int rs2, input int rs1, input int f3);
    logic [12:0] v;
    v = 13'(imm);
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
  endfunction
  function automatic logic [31:0] u_t(input int imm20, input int rd, input int opc);
    return {20'(imm20), 5'(rd), 7'(opc)};
  endfunction
  function automatic logic [31:0] j_t(input int imm, input int rd);
    logic [20:0] v;
    v = 21'(imm);
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6F};
  endfunction
  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return i_t(imm, rs1, 0, rd, 'h13);
  endfunction

  task automatic emit(input logic [31:0] ins, input logic chk, input logic [3:0] wen,
                      input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    rom[apc[10:2]] = ins;
    e.pc = apc; e.chk_addr = chk; e.wen = wen; e.addr = addr; e.wdata = wd;
    sb.push_back(e);
    apc += 32'd4;
  endtask

  task automatic plain(input logic [31:0] ins);
    emit(ins, 1'b0, 4'b0000, 32'h0, 32'h0);
  endtask

  task automatic skip_slot();
    rom[apc[10:2]] = s_t(0, 1, 0, 2);
    apc += 32'd4;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    exp_t        e;
    int          n;
    logic [31:0] jpc, auipc_exp;

    rst_n = 1'b0;
    for (int i = 0; i < 512; i++) rom[i] = 32'h0000_0013;
    rom[0] = s_t(0, 1, 0, 2);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_pc", instr_addr, 32'h0);
    chk("reset_wen", {28'd0, data_wenable}, 32'h0);

    apc = 32'h0;
    for (int k = 1; k <= 5; k++) plain(addi(k, 0, k));
    plain(addi(1, 0, -1));
    plain(i_t(32'h404, 1, 5, 2, 'h13));
    plain(i_t(28, 1, 5, 3, 'h13));
    plain(r_t(0, 1, 0, 3, 4));
    plain(addi(0, 0, 5));
    plain(r_t('h20, 2, 3, 0, 20));
    plain(r_t(0, 3, 2, 4, 21));
    plain(r_t(0, 0, 1, 2, 22));
    plain(r_t(0, 3, 3, 1, 23));
    plain(r_t(0, 3, 1, 5, 24));
    plain(r_t(0, 4, 3, 0, 25));
    plain(r_t(0, 23, 4, 6, 26));
    plain(r_t(0, 3, 2, 7, 27));
    plain(i_t('hF0, 1, 7, 28, 'h13));
    plain(i_t('h123, 0, 6, 29, 'h13));
    plain(i_t('hF, 1, 4, 30, 'h13));
    plain(i_t(0, 1, 2, 31, 'h13));
    plain(i_t(-1, 0, 3, 19, 'h13));
    plain(i_t(31, 4, 1, 18, 'h13));
    for (int k = 0; k < 18; k++)
      emit(s_t(4 * k, int'(alu_regs[k]), 0, 2), 1'b1, 4'b1111, 32'(4 * k), alu_vals[k]);

    plain(u_t('h10000, 5, 'h37));
    plain(addi(6, 0, 'h41));
    emit(s_t(0, 6, 5, 0), 1'b1, 4'b0001, 32'h1000_0000, 32'h4141_4141);
    emit(s_t(2, 6, 5, 1), 1'b1, 4'b1100, 32'h1000_0002, 32'h0041_0041);
    emit(s_t(0, 6, 5, 1), 1'b1, 4'b0011, 32'h1000_0000, 32'h0041_0041);
    emit(s_t(3, 6, 5, 0), 1'b1, 4'b1000, 32'h1000_0003, 32'h4141_4141);
    emit(s_t(0, 6, 5, 2), 1'b1, 4'b1111, 32'h1000_0000, 32'h0000_0041);

    plain(u_t('h80000, 8, 'h37));
    emit(i_t(0, 8, 0, 9, 'h03),  1'b1, 4'b0000, 32'h8000_0000, 32'h0);
    emit(i_t(1, 8, 4, 10, 'h03), 1'b1, 4'b0000, 32'h8000_0001, 32'h0);
    emit(i_t(2, 8, 1, 11, 'h03), 1'b1, 4'b0000, 32'h8000_0002, 32'h0);
    emit(i_t(0, 8, 2, 12, 'h03), 1'b1, 4'b0000, 32'h8000_0000, 32'h0);
    emit(i_t(0, 8, 5, 13, 'h03), 1'b1, 4'b0000, 32'h8000_0000, 32'h0);
    emit(i_t(3, 8, 0, 14, 'h03), 1'b1, 4'b0000, 32'h8000_0003, 32'h0);
    for (int k = 0; k < 6; k++)
      emit(s_t(4 * k, int'(ld_regs[k]), 0, 2), 1'b1, 4'b1111, 32'(4 * k), ld_vals[k]);

    auipc_exp = apc + 32'h1000;
    plain(u_t(1, 16, 'h17));
    emit(s_t(0, 16, 0, 2), 1'b1, 4'b1111, 32'h0, auipc_exp);

    plain(b_t(8, 0, 1, 4)); skip_slot();
    plain(b_t(8, 0, 1, 6));
    plain(b_t(8, 0, 0, 0)); skip_slot();
    plain(b_t(8, 0, 0, 1));
    plain(b_t(8, 1, 0, 5)); skip_slot();
    plain(b_t(8, 0, 1, 7)); skip_slot();
    plain(addi(1, 0, 'h400));
    jpc = apc;
    plain(i_t(3, 1, 0, 1, 'h67));
    apc = 32'h402;
    emit(s_t(0, 1, 0, 2), 1'b1, 4'b1111, 32'h0, jpc + 32'd4);
    plain(j_t(10, 15));
    rom[258] = s_t(0, 1, 0, 2);
    rom[259] = s_t(0, 1, 0, 2);
    apc = 32'h410;
    emit(s_t(0, 15, 0, 2), 1'b1, 4'b1111, 32'h0, 32'h40A);

    plain(addi(1, 0, -2));
    plain(addi(2, 0, 3));
    for (int k = 16; k <= 19; k++) plain(addi(k, 0, 'h77));
    plain(r_t(1, 2, 1, 0, 16));
    plain(r_t(1, 2, 1, 1, 17));
    plain(r_t(1, 2, 1, 3, 18));
    plain(r_t(1, 2, 1, 2, 19));
    plain(r_t(1, 2, 1, 4, 20));
`ifdef CPU_MUL_EN
    emit(s_t(0, 16, 0, 2), 1'b1, 4'b1111, 32'h0, 32'hFFFF_FFFA);
    emit(s_t(4, 17, 0, 2), 1'b1, 4'b1111, 32'h4, 32'hFFFF_FFFF);
    emit(s_t(8, 18, 0, 2), 1'b1, 4'b1111, 32'h8, 32'h0000_0002);
    emit(s_t(12, 19, 0, 2), 1'b1, 4'b1111, 32'hC, 32'hFFFF_FFFF);
`else
    emit(s_t(0, 16, 0, 2), 1'b1, 4'b1111, 32'h0, 32'h77);
    emit(s_t(4, 17, 0, 2), 1'b1, 4'b1111, 32'h4, 32'h77);
    emit(s_t(8, 18, 0, 2), 1'b1, 4'b1111, 32'h8, 32'h77);
    emit(s_t(12, 19, 0, 2), 1'b1, 4'b1111, 32'hC, 32'h77);
`endif
    emit(s_t(16, 20, 0, 2), 1'b1, 4'b1111, 32'h10, 32'h10);

    rst_n = 1'b1;
    #1;
    n = sb.size();
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        @(negedge clk); #1;
      end
      e = sb.pop_front();
      chk($sformatf("pc@%0h", e.pc), instr_addr, e.pc);
      chk($sformatf("wen@%0h", e.pc), {28'd0, data_wenable}, {28'd0, e.wen});
      if (e.chk_addr) chk($sformatf("addr@%0h", e.pc), data_addr, e.addr);
      if (e.wen != 4'b0000) chk($sformatf("wdata@%0h", e.pc), data_wdata, e.wdata);
    end

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("rereset_wen", {28'd0, data_wenable}, 32'h0);
    rom[0] = s_t(0, 1, 0, 2);
    rom[1] = s_t(4, 15, 0, 2);
    rst_n = 1'b1;
    #1;
    chk("rereset_pc", instr_addr, 32'h0);
    chk("rereset_x1", data_wdata, 32'h0);
    @(negedge clk); #1;
    chk("rereset_x15", data_wdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_core.md
Name: rv32i_core

Overview:
- Single-cycle RV32I integer core: one instruction fetched, executed and retired per clock.
- Harvard-style interface: a combinational instruction port and a combinational-read / clocked-write data port.
- Sits between a dual-port word ROM (program, read-only data) and a word RAM. System glue decodes data_addr (RAM at addr[31]=1, console byte sink at 0x1000_0000).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- instr_addr  out  32  byte address of current instruction; equals PC, combinational
- instr_data  in  32  instruction word at instr_addr, valid same cycle
- data_addr  out  32  byte effective address of load/store (rs1+imm), unaligned bits included
- data_wdata  out  32  store data, lane-replicated
- data_wenable  out  4  byte-lane write strobes; lane i = bits [8i+7:8i]
- data_rdata  in  32  aligned word at data_addr, valid same cycle (combinational)

Behaviour:
- Reset (rst_n=0 at a clk edge): PC<=RESET_PC; x1..x31<=0. data_wenable=0 whenever rst_n=0.
- Each edge with rst_n=1 retires exactly one instruction: PC and rd update together. No stalls, no pipeline, no handshake.
- x0 always reads 0; writes to x0 discarded.
- Supported: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI, ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA.
- Arithmetic modulo 2^32. Shifts use low 5 bits of the shift amount. SLT/SLTI signed; SLTU/SLTIU unsigned (immediate sign-extended first).
- Next PC:
  - Default PC+4.
  - Taken branch / JAL: PC+imm.
  - JALR: (rs1+imm) with bit0 cleared.
  - JAL/JALR write PC+4 to rd; rd is written after rs1 is read (rd==rs1 is legal).
- Stores drive data_wenable by funct3 and a=data_addr[1:0]:
  - SW: 4'b1111, a ignored. wdata = rs2.
  - SH: 4'b0011 << (2*a[1]). wdata = {2{rs2[15:0]}}.
  - SB: 4'b0001 << a. wdata = {4{rs2[7:0]}}.
  - data_wenable=0 for every non-store instruction.
- Loads select bytes from data_rdata:
  - LW: whole word, a ignored.
  - LH/LHU: halfword at a[1].
  - LB/LBU: byte at a.
  - Sign- or zero-extend per funct3.
  - Misaligned accesses do not trap; they behave as above.
- data_addr=rs1+imm for loads and stores; for other instructions its value is don't-care, but wenable stays 0.
- FENCE, ECALL, EBREAK, CSR ops and any unrecognised encoding: treated as NOP (PC+4, no register or memory write).

Optional Feature:
- Macro CPU_MUL_EN.
- Defined: OP opcode with funct7=7'b0000001 implements RV32M multiplies:
  - MUL: low 32 bits of the product.
  - MULH: high 32 bits, signed×signed.
  - MULHSU: high 32 bits, signed×unsigned.
  - MULHU: high 32 bits, unsigned×unsigned.
  - All single-cycle.
  - DIV/DIVU/REM/REMU remain NOP.
- Undefined: every funct7=0000001 encoding is a NOP.

Decomposition:
- Package cpu_pkg holds:
  - opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_OP)
  - funct3 constants for branch, load/store and ALU
  - alu_op_t enum
- One sub-module, cpu_alu: operands a, b, alu_op → result, plus the compare flags used by branches. Register file and decode stay in the core.

Test Plan:
- Reset: hold rst_n=0 for 1 edge with RESET_PC=0 → instr_addr=0, data_wenable=0; after release, a program of 5 ADDIs retires in 5 cycles with instr_addr stepping 0,4,8,12,16.
- ALU: ADDI x1,x0,-1; SRAI x2,x1,4; SRLI x3,x1,28; SLTU x4,x0,x1 → x2=0xFFFF_FFFF, x3=0xF, x4=1; ADDI x0,x0,5 leaves x0=0.
- Store lanes: x5=0x1000_0000, x6=0x41; SB x6,0(x5) → one cycle with data_addr=0x1000_0000, data_wenable=0001, data_wdata[7:0]=0x41. SH at offset 2 → wenable 1100; SW → 1111.
- Loads: RAM word 0x8000_0000 = 0x8081_F0FF → LB@+0=0xFFFF_FFFF, LBU@+1=0x0000_00F0, LH@+2=0xFFFF_8081, LW=0x8081_F0FF.
- Control flow: BLT x1(-1),x0 taken to +8; BLTU same operands not taken (PC+4); JALR x1,x1,3 with x1=0x100 → PC=0x102, x1=old PC+4.
- CPU_MUL_EN: x1=-2, x2=3 → MUL=0xFFFF_FFFA, MULH=0xFFFF_FFFF, MULHU=0x0000_0002. Without the macro, the same instructions leave rd unchanged.
